irq_vector_ctrl: RTL and testbench

- Interrupt/exception scheduler in front of the instruction fetch path.
- Collects requests from the timer, the UART receiver, the UART transmitter and the decoder's undefined-instruction exception.
- Arbitrates by fixed priority and issues one redirect (take + vector PC) to the PC mux.
- Blocks further requests until the handler returns via jr $26.

---
 rtl/irq_vector_ctrl.sv | 171 +++++++++++++++++
 tb/tb_irq_vector_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_vector_ctrl.sv
// irq_vector_ctrl: fixed-priority interrupt/exception scheduler that issues a
// single PC redirect (take + vec_pc) and blocks new grants until the handler
// returns with jr $26 (eret).
module irq_vector_ctrl #(
  parameter logic [31:0] VEC_EXC   = 32'h00000008,
  parameter logic [31:0] VEC_TIMER = 32'h00000004,
  parameter logic [31:0] VEC_URX   = 32'h00000010,
  parameter logic [31:0] VEC_UTX   = 32'h0000000C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        timer_irq,
  input  logic        uart_rx_pulse,
  input  logic        uart_tx_pulse,
  input  logic        exc_req,
  input  logic        pc_kernel,
  input  logic        stall,
  input  logic        eret,
  input  logic        mask_we,
  input  logic [2:0]  mask_wdata,
  output logic        take,
  output logic [31:0] vec_pc,
  output logic [1:0]  cause,
  output logic        busy,
  output logic [2:0]  pend,
  output logic [1:0]  lost
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_EXC   = 2'd0;
  localparam logic [1:0] CAUSE_TIMER = 2'd1;
  localparam logic [1:0] CAUSE_URX   = 2'd2;
  localparam logic [1:0] CAUSE_UTX   = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] vec_pc_q, vec_pc_d;
  logic        urx_p_q, urx_p_d;
  logic        utx_p_q, utx_p_d;
  logic [1:0]  lost_q, lost_d;
  logic [2:0]  mask_q, mask_d;

  logic grant_done;
  logic urx_clr;
  logic utx_clr;
  logic arb_timer;
  logic arb_urx;
  logic arb_utx;

  // Next-state, arbitration, pending-latch and mask/overrun bookkeeping
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    vec_pc_d = vec_pc_q;
    urx_p_d  = urx_p_q;
    utx_p_d  = utx_p_q;
    lost_d   = lost_q;
    mask_d   = mask_q;

    // The redirect is accepted on a GRANT edge with no stall; only then is
    // the winning source's latch consumed.
    grant_done = (state_q == S_GRANT) && !stall;
    urx_clr    = grant_done && (cause_q == CAUSE_URX);
    utx_clr    = grant_done && (cause_q == CAUSE_UTX);

    // UART pulses are bypassed into arbitration so a pulse in cycle N
    // produces take in cycle N+1, same as level requests.
    arb_timer = timer_irq & mask_q[0];
    arb_urx   = (urx_p_q | uart_rx_pulse) & mask_q[1];
    arb_utx   = (utx_p_q | uart_tx_pulse) & mask_q[2];

    case (state_q)
      S_IDLE: begin
        if (!pc_kernel && (exc_req || arb_timer || arb_urx || arb_utx)) begin
          state_d = S_GRANT;
          if (exc_req) begin
            cause_d  = CAUSE_EXC;
            vec_pc_d = VEC_EXC;
          end else if (arb_timer) begin
            cause_d  = CAUSE_TIMER;
            vec_pc_d = VEC_TIMER;
          end else if (arb_urx) begin
            cause_d  = CAUSE_URX;
            vec_pc_d = VEC_URX;
          end else begin
            cause_d  = CAUSE_UTX;
            vec_pc_d = VEC_UTX;
          end
        end
      end
      S_GRANT: begin
        // Winner is frozen while stalled; no re-arbitration here.
        if (!stall) begin
          state_d = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (eret) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A mask write clears the overrun flags; a fresh overrun in the same
    // cycle still gets recorded below.
    if (mask_we) begin
      mask_d = mask_wdata;
      lost_d = 2'b00;
    end

    // Overrun: a pulse hits a latch that is still full and is not being
    // consumed this cycle.
    if (uart_rx_pulse && urx_p_q && !urx_clr) begin
      lost_d[0] = 1'b1;
    end
    if (uart_tx_pulse && utx_p_q && !utx_clr) begin
      lost_d[1] = 1'b1;
    end

    // Clear first, then set, so a coincident pulse survives.
    if (urx_clr) begin
      urx_p_d = 1'b0;
    end
    if (uart_rx_pulse) begin
      urx_p_d = 1'b1;
    end
    if (utx_clr) begin
      utx_p_d = 1'b0;
    end
    if (uart_tx_pulse) begin
      utx_p_d = 1'b1;
    end
  end

  // State and bookkeeping registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cause_q  <= 2'd0;
      vec_pc_q <= 32'd0;
      urx_p_q  <= 1'b0;
      utx_p_q  <= 1'b0;
      lost_q   <= 2'b00;
      mask_q   <= 3'b111;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      vec_pc_q <= vec_pc_d;
      urx_p_q  <= urx_p_d;
      utx_p_q  <= utx_p_d;
      lost_q   <= lost_d;
      mask_q   <= mask_d;
    end
  end

  assign take   = (state_q == S_GRANT);
  assign busy   = (state_q == S_SERVICE);
  assign vec_pc = vec_pc_q;
  assign cause  = cause_q;
  assign pend   = {utx_p_q & mask_q[2], urx_p_q & mask_q[1], timer_irq & mask_q[0]};
  assign lost   = lost_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Directed testbench for irq_vector_ctrl: linear stimulus, immediate-assertion
// checks against hand-computed expectations.
`timescale 1ns/1ps
module tb_irq_vector_ctrl;

  logic        clk;
  logic        reset;
  logic        timer_irq;
  logic        uart_rx_pulse;
  logic        uart_tx_pulse;
  logic        exc_req;
  logic        pc_kernel;
  logic        stall;
  logic        eret;
  logic        mask_we;
  logic [2:0]  mask_wdata;
  logic        take;
  logic [31:0] vec_pc;
  logic [1:0]  cause;
  logic        busy;
  logic [2:0]  pend;
  logic [1:0]  lost;

  int n_total;
  int n_pass;

  irq_vector_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .timer_irq     (timer_irq),
    .uart_rx_pulse (uart_rx_pulse),
    .uart_tx_pulse (uart_tx_pulse),
    .exc_req       (exc_req),
    .pc_kernel     (pc_kernel),
    .stall         (stall),
    .eret          (eret),
    .mask_we       (mask_we),
    .mask_wdata    (mask_wdata),
    .take          (take),
    .vec_pc        (vec_pc),
    .cause         (cause),
    .busy          (busy),
    .pend          (pend),
    .lost          (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven and outputs sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1; timer_irq = 1'b0; uart_rx_pulse = 1'b0; uart_tx_pulse = 1'b0;
    exc_req = 1'b0; pc_kernel = 1'b0; stall = 1'b0; eret = 1'b0;
    mask_we = 1'b0; mask_wdata = 3'b000;

    // Reset state
    step(); step();
    chk("rst_take", {31'd0, take}, 32'd0);
    chk("rst_vec", vec_pc, 32'd0);
    chk("rst_cause", {30'd0, cause}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pend", {29'd0, pend}, 32'd0);
    chk("rst_lost", {30'd0, lost}, 32'd0);
    reset = 1'b0;
    step();
    $display("reset released");

    // URX pulse -> take next cycle, then SERVICE with latch cleared
    uart_rx_pulse = 1'b1;
    step();
    uart_rx_pulse = 1'b0;
    chk("urx_take", {31'd0, take}, 32'd1);
    chk("urx_vec", vec_pc, 32'h10);
    chk("urx_cause", {30'd0, cause}, 32'd2);
    chk("urx_pend_set", {29'd0, pend}, 32'd2);
    step();
    chk("urx_busy", {31'd0, busy}, 32'd1);
    chk("urx_take_off", {31'd0, take}, 32'd0);
    chk("urx_pend_clr", {29'd0, pend}, 32'd0);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("urx_ret_busy", {31'd0, busy}, 32'd0);
    $display("urx single request done");

    // Simultaneous exc + timer + urx -> exc, then timer, then urx
    timer_irq = 1'b1; uart_rx_pulse = 1'b1; exc_req = 1'b1;
    step();
    uart_rx_pulse = 1'b0; exc_req = 1'b0;
    chk("pri_exc_vec", vec_pc, 32'h8);
    chk("pri_exc_cause", {30'd0, cause}, 32'd0);
    step();
    chk("pri_exc_busy", {31'd0, busy}, 32'd1);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("pri_gap_take", {31'd0, take}, 32'd0);
    step();
    chk("pri_tmr_take", {31'd0, take}, 32'd1);
    chk("pri_tmr_vec", vec_pc, 32'h4);
    chk("pri_tmr_cause", {30'd0, cause}, 32'd1);
    step();
    timer_irq = 1'b0;
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    chk("pri_urx_take", {31'd0, take}, 32'd1);
    chk("pri_urx_vec", vec_pc, 32'h10);
    chk("pri_urx_cause", {30'd0, cause}, 32'd2);
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    $display("priority sequence done");

    // Timer with stall: take and vector held, no SERVICE until stall drops
    timer_irq = 1'b1; stall = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("stall_take", {31'd0, take}, 32'd1);
      chk("stall_vec", vec_pc, 32'h4);
      chk("stall_busy", {31'd0, busy}, 32'd0);
      step();
    end
    chk("stall_take_last", {31'd0, take}, 32'd1);
    stall = 1'b0;
    step();
    chk("stall_svc_busy", {31'd0, busy}, 32'd1);
    chk("stall_svc_take", {31'd0, take}, 32'd0);
    timer_irq = 1'b0;
    eret = 1'b1;
    step();
    eret = 1'b0;
    $display("stall hold done");

    // Mask off the timer, then re-enable it
    mask_we = 1'b1; mask_wdata = 3'b110;
    step();
    mask_we = 1'b0;
    timer_irq = 1'b1;
    step();
    chk("mask_take", {31'd0, take}, 32'd0);
    chk("mask_pend", {29'd0, pend}, 32'd0);
    step();
    chk("mask_take2", {31'd0, take}, 32'd0);
    mask_we = 1'b1; mask_wdata = 3'b111;
    step();
    mask_we = 1'b0;
    chk("unmask_take_w1", {31'd0, take}, 32'd0);
    chk("unmask_pend", {29'd0, pend}, 32'd1);
    step();
    chk("unmask_take_w2", {31'd0, take}, 32'd1);
    chk("unmask_cause", {30'd0, cause}, 32'd1);
    timer_irq = 1'b0;
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    $display("mask sequence done");

    // Two UTX pulses during SERVICE -> overrun flag, one utx service
    timer_irq = 1'b1;
    step();
    step();
    timer_irq = 1'b0;
    chk("lost_svc_busy", {31'd0, busy}, 32'd1);
    uart_tx_pulse = 1'b1;
    step();
    uart_tx_pulse = 1'b0;
    chk("lost_first", {30'd0, lost}, 32'd0);
    step(); step(); step();
    uart_tx_pulse = 1'b1;
    step();
    uart_tx_pulse = 1'b0;
    chk("lost_set", {30'd0, lost}, 32'd2);
    chk("lost_pend", {29'd0, pend}, 32'd4);
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    chk("utx_take", {31'd0, take}, 32'd1);
    chk("utx_vec", vec_pc, 32'hC);
    chk("utx_cause", {30'd0, cause}, 32'd3);
    step();
    chk("utx_pend_clr", {29'd0, pend}, 32'd0);
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();
    chk("utx_single", {31'd0, take}, 32'd0);
    chk("lost_held", {30'd0, lost}, 32'd2);
    mask_we = 1'b1; mask_wdata = 3'b111;
    step();
    mask_we = 1'b0;
    chk("lost_clr", {30'd0, lost}, 32'd0);
    $display("overrun sequence done");

    // Reset during SERVICE aborts to IDLE
    timer_irq = 1'b1;
    step();
    step();
    timer_irq = 1'b0;
    chk("rsvc_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    chk("rsvc_busy", {31'd0, busy}, 32'd0);
    chk("rsvc_take", {31'd0, take}, 32'd0);
    chk("rsvc_pend", {29'd0, pend}, 32'd0);
    reset = 1'b0;
    step();
    chk("rsvc_take_after", {31'd0, take}, 32'd0);
    $display("reset in service done");

    // eret while IDLE is ignored
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("eret_idle_take", {31'd0, take}, 32'd0);
    chk("eret_idle_busy", {31'd0, busy}, 32'd0);
    $display("eret in idle done");

    // pc_kernel suppresses grants until it drops
    pc_kernel = 1'b1; timer_irq = 1'b1;
    step();
    step();
    chk("kern_take", {31'd0, take}, 32'd0);
    chk("kern_pend", {29'd0, pend}, 32'd1);
    pc_kernel = 1'b0;
    step();
    chk("kern_release_take", {31'd0, take}, 32'd1);
    chk("kern_release_cause", {30'd0, cause}, 32'd1);
    timer_irq = 1'b0;
    $display("kernel suppression done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
